// File: rtl/beam_pkg.sv
// Shared types and constants for the beam_mux burst scheduler slice.
package beam_pkg;

    localparam logic [1:0] SEL_RR   = 2'b00;
    localparam logic [1:0] SEL_DAC1 = 2'b01;
    localparam logic [1:0] SEL_DAC2 = 2'b10;
    localparam logic [1:0] SEL_DAC3 = 2'b11;

    localparam int SCHED_CWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } sched_state_t;

    // Layout of one table word at the default burst-count width.
    typedef struct packed {
        logic [1:0]              sel;
        logic [SCHED_CWIDTH-1:0] count;
    } sched_entry_t;

endpackage

// File: rtl/beam_dac_sched_if.sv
// AXIS valid/ready/last handshake passing through the scheduler gate.
interface beam_dac_sched_if;

    logic up_tvalid;
    logic up_tready;
    logic up_tlast;
    logic mux_tvalid;
    logic mux_tready;

    modport master (
        output up_tvalid,
        output up_tlast,
        output mux_tready,
        input  up_tready,
        input  mux_tvalid
    );

    modport slave (
        input  up_tvalid,
        input  up_tlast,
        input  mux_tready,
        output up_tready,
        output mux_tvalid
    );

endinterface

// File: rtl/beam_sched_table.sv
// Schedule table: DEPTH entries of (sel, count), one write port, one
// combinational read port, contents survive reset.
module beam_sched_table #(
    parameter int DEPTH  = 16,
    parameter int CWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [1:0]               wr_sel,
    input  logic [CWIDTH-1:0]        wr_count,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [1:0]               rd_sel,
    output logic [CWIDTH-1:0]        rd_count
);

    logic [1:0]        sel_mem [DEPTH];
    logic [CWIDTH-1:0] cnt_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            sel_mem[wr_addr] <= wr_sel;
            cnt_mem[wr_addr] <= wr_count;
        end
    end

    assign rd_sel   = sel_mem[rd_addr];
    assign rd_count = cnt_mem[rd_addr];

endmodule

// File: rtl/beam_dac_sched.sv
// Burst scheduler in front of beam_mux: steps dac_sel through a table and
// gates the AXIS handshake. Optional statistics: define BEAM_SCHED_STATS_EN.
module beam_dac_sched
    import beam_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr_en,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [1:0]               cfg_sel,
    input  logic [CWIDTH-1:0]        cfg_count,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     cfg_loop,
    input  logic                     start,
    input  logic                     stop,
    beam_dac_sched_if.slave          axis,
    output logic [1:0]               dac_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic [31:0]              burst_cnt_dac1,
    output logic [31:0]              burst_cnt_dac2,
    output logic [31:0]              burst_cnt_dac3
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    sched_state_t      state, state_n;
    logic [AW-1:0]     idx;
    logic [CWIDTH-1:0] rem;
    logic [AW:0]       len_q;
    logic              loop_q;
    logic              in_burst;
    logic              stop_pending;

    logic              open_gate;
    logic              beat;
    logic              burst_end;
    logic              len_ok;
    logic              last_entry;
    logic              rem_last;
    logic              accept_start;
    logic              advance;
    logic              wrap;
    logic              rem_dec;
    logic              err_n;

    logic [1:0]        tbl_sel;
    logic [CWIDTH-1:0] tbl_count;

    beam_sched_table #(
        .DEPTH  (DEPTH),
        .CWIDTH (CWIDTH)
    ) u_table (
        .clk      (clk),
        .wr_en    (cfg_wr_en && (state == IDLE)),
        .wr_addr  (cfg_addr),
        .wr_sel   (cfg_sel),
        .wr_count (cfg_count),
        .rd_addr  (idx),
        .rd_sel   (tbl_sel),
        .rd_count (tbl_count)
    );

    // Gate is purely a function of state so reset closes it at once.
    assign open_gate       = (state == RUN) && !(stop_pending && !in_burst);
    assign axis.mux_tvalid = axis.up_tvalid & open_gate;
    assign axis.up_tready  = axis.mux_tready & open_gate;
    assign beat            = axis.up_tvalid & axis.up_tready;
    assign burst_end       = beat & axis.up_tlast;

    assign len_ok     = (cfg_len != '0) && (cfg_len <= DEPTH_L);
    assign last_entry = ({1'b0, idx} == (len_q - ONE_L));
    assign rem_last   = (rem == CWIDTH'(1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        accept_start = 1'b0;
        advance      = 1'b0;
        wrap         = 1'b0;
        rem_dec      = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        accept_start = 1'b1;
                        state_n      = LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD: state_n = RUN;
            RUN: begin
                // A stop arriving with the closing tlast still ends on this boundary.
                if (burst_end) begin
                    if (!rem_last) begin
                        rem_dec = 1'b1;
                    end else if (stop_pending || stop) begin
                        state_n = DONE;
                    end else if (!last_entry) begin
                        advance = 1'b1;
                        state_n = LOAD;
                    end else if (loop_q) begin
                        wrap    = 1'b1;
                        state_n = LOAD;
                    end else begin
                        state_n = DONE;
                    end
                end else if (stop_pending && !in_burst && !beat) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if ((state != IDLE) && (start || cfg_wr_en)) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            rem          <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            in_burst     <= 1'b0;
            stop_pending <= 1'b0;
            dac_sel      <= SEL_RR;
            cur_idx      <= '0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err <= err_n;

            if (accept_start) begin
                len_q  <= cfg_len;
                loop_q <= cfg_loop;
                idx    <= '0;
            end else if (advance) begin
                idx <= idx + AW'(1);
            end else if (wrap) begin
                idx <= '0;
            end

            // A zero count still runs one burst so rem can never underflow.
            if (state == LOAD) begin
                dac_sel <= tbl_sel;
                rem     <= (tbl_count == '0) ? CWIDTH'(1) : tbl_count;
                cur_idx <= idx;
            end else if (rem_dec) begin
                rem <= rem - CWIDTH'(1);
            end

            if (((state == LOAD) || (state == RUN)) && stop) begin
                stop_pending <= 1'b1;
            end else if (state == DONE) begin
                stop_pending <= 1'b0;
            end

            if (burst_end || (state == DONE)) begin
                in_burst <= 1'b0;
            end else if (beat) begin
                in_burst <= 1'b1;
            end
        end
    end

`ifdef BEAM_SCHED_STATS_EN
    logic [31:0] cnt_dac1, cnt_dac2, cnt_dac3;

    // Bursts are attributed to the selection the mux saw while they ran.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_dac1 <= '0;
            cnt_dac2 <= '0;
            cnt_dac3 <= '0;
        end else if (accept_start) begin
            cnt_dac1 <= '0;
            cnt_dac2 <= '0;
            cnt_dac3 <= '0;
        end else if (burst_end) begin
            case (dac_sel)
                SEL_DAC1: cnt_dac1 <= cnt_dac1 + 32'd1;
                SEL_DAC2: cnt_dac2 <= cnt_dac2 + 32'd1;
                SEL_DAC3: cnt_dac3 <= cnt_dac3 + 32'd1;
                default:  ;
            endcase
        end
    end

    assign burst_cnt_dac1 = cnt_dac1;
    assign burst_cnt_dac2 = cnt_dac2;
    assign burst_cnt_dac3 = cnt_dac3;
`else
    assign burst_cnt_dac1 = '0;
    assign burst_cnt_dac2 = '0;
    assign burst_cnt_dac3 = '0;
`endif

endmodule

// File: tb/tb_beam_dac_sched.sv
// Directed self-checking bench for beam_dac_sched (stats checks follow
// BEAM_SCHED_STATS_EN).
module tb_beam_dac_sched;

    import beam_pkg::*;

    localparam int DEPTH  = 16;
    localparam int CWIDTH = 16;
    localparam int AW     = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              cfg_wr_en;
    logic [AW-1:0]     cfg_addr;
    logic [1:0]        cfg_sel;
    logic [CWIDTH-1:0] cfg_count;
    logic [AW:0]       cfg_len;
    logic              cfg_loop;
    logic              start;
    logic              stop;
    logic [1:0]        dac_sel;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [AW-1:0]     cur_idx;
    logic [31:0]       burst_cnt_dac1;
    logic [31:0]       burst_cnt_dac2;
    logic [31:0]       burst_cnt_dac3;

    int n_asserts = 0;
    int n_fails   = 0;

    beam_dac_sched_if axis_if ();

    beam_dac_sched #(
        .DEPTH  (DEPTH),
        .CWIDTH (CWIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_addr       (cfg_addr),
        .cfg_sel        (cfg_sel),
        .cfg_count      (cfg_count),
        .cfg_len        (cfg_len),
        .cfg_loop       (cfg_loop),
        .start          (start),
        .stop           (stop),
        .axis           (axis_if),
        .dac_sel        (dac_sel),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .cur_idx        (cur_idx),
        .burst_cnt_dac1 (burst_cnt_dac1),
        .burst_cnt_dac2 (burst_cnt_dac2),
        .burst_cnt_dac3 (burst_cnt_dac3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeEntry(input logic [AW-1:0] addr, input logic [1:0] sel,
                              input logic [CWIDTH-1:0] cnt);
        cfg_wr_en = 1'b1;
        cfg_addr  = addr;
        cfg_sel   = sel;
        cfg_count = cnt;
        cycle();
        cfg_wr_en = 1'b0;
        #1;
    endtask

    task automatic startSched(input logic [AW:0] len, input logic loop);
        cfg_len  = len;
        cfg_loop = loop;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        #1;
    endtask

    // Offers one burst of nbeats, raising stop alongside beat stop_beat
    // (-1 for none); reports the selection of the first beat and how many
    // closed cycles were spent waiting.
    task automatic applyStimulus(input int nbeats, input int stop_beat,
                                 output logic [1:0] sel_seen, output int waits);
        int b;
        b        = 0;
        waits    = 0;
        sel_seen = 2'b00;
        axis_if.up_tvalid = 1'b1;
        while ((b < nbeats) && (waits < 20)) begin
            axis_if.up_tlast = (b == nbeats - 1);
            stop             = (b == stop_beat);
            #1;
            if (axis_if.up_tready) begin
                if (b == 0) sel_seen = dac_sel;
                checkOutput("mux_tvalid_beat", axis_if.mux_tvalid, 1);
                b++;
            end else begin
                waits++;
            end
            cycle();
        end
        axis_if.up_tvalid = 1'b0;
        axis_if.up_tlast  = 1'b0;
        stop              = 1'b0;
        #1;
        checkOutput("burst_beats", b, nbeats);
    endtask

    logic [1:0] sel_got;
    int         wait_got;

    logic [1:0] exp_sel1 [3] = '{SEL_DAC1, SEL_DAC1, SEL_DAC2};
    int         exp_wait1[3] = '{1, 0, 1};
    logic [1:0] exp_sel2 [6] = '{SEL_DAC1, SEL_DAC1, SEL_DAC2, SEL_DAC1, SEL_DAC1, SEL_DAC2};
    int         exp_wait2[6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        rst                = 1'b1;
        cfg_wr_en          = 1'b0;
        cfg_addr           = '0;
        cfg_sel            = 2'b00;
        cfg_count          = '0;
        cfg_len            = '0;
        cfg_loop           = 1'b0;
        start              = 1'b0;
        stop               = 1'b0;
        axis_if.up_tvalid  = 1'b0;
        axis_if.up_tlast   = 1'b0;
        axis_if.mux_tready = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_dac_sel", dac_sel, 0);
        checkOutput("rst_cur_idx", cur_idx, 0);
        checkOutput("rst_up_tready", axis_if.up_tready, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        $display("[TB] Two-entry schedule, no loop");
        writeEntry(0, SEL_DAC1, 2);
        writeEntry(1, SEL_DAC2, 1);
        checkOutput("wr_idle_no_err", cfg_err, 0);
        startSched(2, 1'b0);
        checkOutput("busy_after_start", busy, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, -1, sel_got, wait_got);
            checkOutput($sformatf("t1_sel%0d", i), sel_got, exp_sel1[i]);
            checkOutput($sformatf("t1_wait%0d", i), wait_got, exp_wait1[i]);
        end
        checkOutput("t1_done_pulse", done, 1);
        checkOutput("t1_gate_closed", axis_if.up_tready, 0);
`ifdef BEAM_SCHED_STATS_EN
        checkOutput("t1_stat_dac1", burst_cnt_dac1, 2);
        checkOutput("t1_stat_dac2", burst_cnt_dac2, 1);
        checkOutput("t1_stat_dac3", burst_cnt_dac3, 0);
`endif
        cycle();
        checkOutput("t1_done_low", done, 0);
        checkOutput("t1_busy_low", busy, 0);
        checkOutput("t1_sel_hold", dac_sel, SEL_DAC2);

        $display("[TB] Two-entry schedule, looping");
        startSched(2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, -1, sel_got, wait_got);
            checkOutput($sformatf("t2_sel%0d", i), sel_got, exp_sel2[i]);
            checkOutput($sformatf("t2_wait%0d", i), wait_got, exp_wait2[i]);
            checkOutput($sformatf("t2_no_done%0d", i), done, 0);
        end
        checkOutput("t2_busy", busy, 1);
        cycle();
        checkOutput("t2_cur_idx_wrap", cur_idx, 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        #1;
        checkOutput("t2_stop_gate", axis_if.up_tready, 0);
        cycle();
        checkOutput("t2_stop_done", done, 1);
        cycle();
        checkOutput("t2_idle", busy, 0);

        $display("[TB] Stop during an 8-beat burst");
        writeEntry(0, SEL_DAC3, 3);
        startSched(1, 1'b0);
        cycle();
        axis_if.up_tvalid  = 1'b1;
        axis_if.mux_tready = 1'b0;
        #1;
        checkOutput("t3_backpressure_ready", axis_if.up_tready, 0);
        checkOutput("t3_backpressure_valid", axis_if.mux_tvalid, 1);
        axis_if.up_tvalid  = 1'b0;
        axis_if.mux_tready = 1'b1;
        #1;
        applyStimulus(8, 2, sel_got, wait_got);
        checkOutput("t3_sel", sel_got, SEL_DAC3);
        checkOutput("t3_wait", wait_got, 0);
        axis_if.up_tvalid = 1'b1;
        #1;
        checkOutput("t3_ready_after_tlast", axis_if.up_tready, 0);
        checkOutput("t3_valid_after_tlast", axis_if.mux_tvalid, 0);
        checkOutput("t3_done_not_yet", done, 0);
        axis_if.up_tvalid = 1'b0;
        cycle();
        checkOutput("t3_done_pulse", done, 1);
        cycle();
        checkOutput("t3_done_once", done, 0);
        checkOutput("t3_idle", busy, 0);

        $display("[TB] Zero burst count treated as one");
        writeEntry(0, SEL_DAC1, 0);
        startSched(1, 1'b0);
        applyStimulus(2, -1, sel_got, wait_got);
        checkOutput("t4_sel", sel_got, SEL_DAC1);
        checkOutput("t4_done", done, 1);
        cycle();
        axis_if.up_tvalid = 1'b1;
        #1;
        checkOutput("t4_no_second_burst", axis_if.up_tready, 0);
        axis_if.up_tvalid = 1'b0;
        #1;

        $display("[TB] Rejected start and config writes");
        startSched(0, 1'b0);
        checkOutput("t5_len0_err", cfg_err, 1);
        checkOutput("t5_len0_busy", busy, 0);
        cycle();
        checkOutput("t5_err_pulse", cfg_err, 0);
        startSched(5'(DEPTH + 1), 1'b0);
        checkOutput("t5_len_big_err", cfg_err, 1);
        checkOutput("t5_len_big_busy", busy, 0);
        startSched(1, 1'b0);
        checkOutput("t5_good_start", cfg_err, 0);
        cycle();
        writeEntry(0, SEL_DAC3, 5);
        checkOutput("t5_wr_busy_err", cfg_err, 1);
        applyStimulus(2, -1, sel_got, wait_got);
        checkOutput("t5_run_done", done, 1);
        cycle();
        startSched(1, 1'b0);
        applyStimulus(3, -1, sel_got, wait_got);
        checkOutput("t5_readback_sel", sel_got, SEL_DAC1);
        checkOutput("t5_readback_done", done, 1);
        cycle();

        $display("[TB] Reset in the middle of a burst");
        startSched(1, 1'b0);
        cycle();
        axis_if.up_tvalid = 1'b1;
        axis_if.up_tlast  = 1'b0;
        cycle();
        cycle();
        checkOutput("t6_open_before_rst", axis_if.up_tready, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_ready_drop", axis_if.up_tready, 0);
        checkOutput("t6_valid_drop", axis_if.mux_tvalid, 0);
        checkOutput("t6_dac_sel", dac_sel, SEL_RR);
        checkOutput("t6_busy", busy, 0);
`ifdef BEAM_SCHED_STATS_EN
        checkOutput("t6_stat_dac1", burst_cnt_dac1, 0);
        checkOutput("t6_stat_dac2", burst_cnt_dac2, 0);
        checkOutput("t6_stat_dac3", burst_cnt_dac3, 0);
`endif
        axis_if.up_tvalid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
